// File: rtl/cache_miss_handler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_handler_pkg
// Description : Shared definitions for the 4-way, 256-set data cache:
//               geometry constants, the miss-handler state encoding and
//               address-slicing helpers used by the controller, the data
//               array and the miss handler.
// Contents    : ADDR_W, DATA_W, INDEX_W, TAG_W, WAYS, WAY_W constants;
//               cmh_state_e state enum; addr_tag()/addr_index() helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_miss_handler_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 8;
  localparam int TAG_W   = 22;
  localparam int WAYS    = 4;
  localparam int WAY_W   = 2;

  // One word per line, so the two byte-offset bits sit directly below the index.
  localparam int OFFS_W  = ADDR_W - TAG_W - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_FILL    = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_DONE    = 3'd6
  } cmh_state_e;

  // Tag = Addr[31:10]
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  // Index = Addr[9:2]
  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFS_W +: INDEX_W];
  endfunction

endpackage : cache_miss_handler_pkg
`default_nettype wire

// File: rtl/cache_miss_handler_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_handler_if
// Description : Main-memory bus between the miss handler and memory.
//               Request channel uses a valid/ready handshake; the response
//               channel is a single valid strobe (read data or write ack).
// Signals     : mem_req_valid/mem_req_ready  request handshake
//               mem_req_we/addr/wdata        request payload
//               mem_resp_valid/mem_resp_data response (data or ack)
// Modports    : master - cache side (drives requests)
//               slave  - memory side (drives ready and responses)
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_miss_handler_if;
  import cache_miss_handler_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );

endinterface : cache_miss_handler_if
`default_nettype wire

// File: rtl/cache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_handler
// Description : Read-miss refill and write-through engine for the MEM-stage
//               data cache. Stalls the pipeline while a main-memory
//               transaction is outstanding, refills the victim way on a
//               read miss, and forwards every cacheable store to memory
//               (no write-allocate).
// Ports       : clk, rst_n              clock, async active-low reset
//               Usecache_i, MemWrite_i  cacheable access / store qualifier
//               Addr_i, WriteData_i     access address and store data
//               Hit_i, BLK_NUM_i        controller hit flag and chosen way
//               Stall_o                 pipeline freeze
//               mem (master modport)    main-memory request/response bus
//               Fill_*_o                refill write into data/tag arrays
// Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_handler
  import cache_miss_handler_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,

  input  wire logic               Usecache_i,
  input  wire logic               MemWrite_i,
  input  wire logic [ADDR_W-1:0]  Addr_i,
  input  wire logic [DATA_W-1:0]  WriteData_i,
  input  wire logic               Hit_i,
  input  wire logic [WAY_W-1:0]   BLK_NUM_i,

  output logic                    Stall_o,

  cache_miss_handler_if.master    mem,

  output logic                    Fill_en_o,
  output logic [WAY_W-1:0]        Fill_way_o,
  output logic [INDEX_W-1:0]      Fill_index_o,
  output logic [TAG_W-1:0]        Fill_tag_o,
  output logic [DATA_W-1:0]       Fill_data_o
);

  // --------------------------------------------------------------------------
  // State and latched access
  // --------------------------------------------------------------------------
  cmh_state_e          state_q, state_d;

  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  index_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WAY_W-1:0]    way_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                w_latch_en;
  logic                w_capture_en;
  logic                w_stall;
  logic                w_req_valid;
  logic                w_req_we;
  logic                w_fill_en;

  // The byte offset never reaches memory: requests are word aligned.
  logic                w_unused_offset;
  assign w_unused_offset = ^Addr_i[OFFS_W-1:0];

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    w_latch_en   = 1'b0;
    w_capture_en = 1'b0;
    w_stall      = 1'b0;
    w_req_valid  = 1'b0;
    w_req_we     = 1'b0;
    w_fill_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Stores are written through whether they hit or not; loads only
        // leave IDLE on a miss. The stall is raised in the detect cycle so
        // the access is held in MEM while the handler takes over.
        if (Usecache_i && MemWrite_i) begin
          state_d    = S_WR_REQ;
          w_latch_en = 1'b1;
          w_stall    = 1'b1;
        end else if (Usecache_i && !Hit_i) begin
          state_d    = S_RD_REQ;
          w_latch_en = 1'b1;
          w_stall    = 1'b1;
        end
      end

      S_RD_REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        if (mem.mem_req_ready) begin
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        w_stall = 1'b1;
        if (mem.mem_resp_valid) begin
          w_capture_en = 1'b1;
          state_d      = S_FILL;
        end
      end

      S_FILL: begin
        // Stall still held so the replay samples the cache after the
        // arrays have been written; it then hits and IDLE stays put.
        w_stall   = 1'b1;
        w_fill_en = 1'b1;
        state_d   = S_IDLE;
      end

      S_WR_REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        w_req_we    = 1'b1;
        if (mem.mem_req_ready) begin
          state_d = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        w_stall = 1'b1;
        if (mem.mem_resp_valid) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // One unstalled cycle lets the store retire. Returning to IDLE
        // afterwards means the same store is not seen again.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Access latch: captured when leaving IDLE so that later changes on the
  // controller side (notably the LRU update of BLK_NUM) cannot disturb the
  // request payload or the refill way.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      index_q <= '0;
      wdata_q <= '0;
      way_q   <= '0;
    end else if (w_latch_en) begin
      tag_q   <= addr_tag(Addr_i);
      index_q <= addr_index(Addr_i);
      wdata_q <= WriteData_i;
      way_q   <= BLK_NUM_i;
    end
  end

  // Read data is only taken in RD_WAIT; responses in any other state,
  // including stale ones after a reset, are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (w_capture_en) begin
      rdata_q <= mem.mem_resp_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Stall_o           = w_stall;

  assign mem.mem_req_valid = w_req_valid;
  assign mem.mem_req_we    = w_req_we;
  assign mem.mem_req_addr  = {tag_q, index_q, {OFFS_W{1'b0}}};
  assign mem.mem_req_wdata = wdata_q;

  assign Fill_en_o         = w_fill_en;
  assign Fill_way_o        = way_q;
  assign Fill_index_o      = index_q;
  assign Fill_tag_o        = tag_q;
  assign Fill_data_o       = rdata_q;

endmodule : cache_miss_handler
`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_miss_handler
// Description : Directed, self-checking bench for cache_miss_handler.
//               IDLE stall decode is table driven under reset; refill,
//               write-through, way latching, reset abort and back-to-back
//               misses are hand-written cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_miss_handler;
  import cache_miss_handler_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        Usecache, MemWrite, Hit;
  logic [31:0] Addr, WriteData;
  logic [1:0]  BLK;
  logic        Stall;
  logic        Fill_en;
  logic [1:0]  Fill_way;
  logic [7:0]  Fill_index;
  logic [21:0] Fill_tag;
  logic [31:0] Fill_data;

  int n_checks = 0;
  int n_errors = 0;

  cache_miss_handler_if mem_if ();

  cache_miss_handler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Usecache_i   (Usecache),
    .MemWrite_i   (MemWrite),
    .Addr_i       (Addr),
    .WriteData_i  (WriteData),
    .Hit_i        (Hit),
    .BLK_NUM_i    (BLK),
    .Stall_o      (Stall),
    .mem          (mem_if.master),
    .Fill_en_o    (Fill_en),
    .Fill_way_o   (Fill_way),
    .Fill_index_o (Fill_index),
    .Fill_tag_o   (Fill_tag),
    .Fill_data_o  (Fill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Read miss starting at posedge+1. Ready is always high, the response
  // arrives L cycles after the request, a junk response is offered during
  // RD_REQ (must be ignored), BLK_NUM and Addr change after detection, and
  // the replay hits from cycle 3+L.
  task automatic read_miss(input logic [31:0] a, input logic [1:0] w,
                           input logic [1:0] w_later, input logic [31:0] d,
                           input int L, input string nm);
    int stall_cnt = 0;
    int fill_cnt  = 0;
    int fill_cyc  = -1;
    int req_cnt   = 0;
    Usecache = 1'b1; MemWrite = 1'b0; Hit = 1'b0; Addr = a; BLK = w;
    mem_if.mem_req_ready  = 1'b1;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data  = 32'hBAD0_0000;
    for (int c = 0; c < L + 8; c++) begin
      @(negedge clk);
      if (Stall) stall_cnt++;
      if (mem_if.mem_req_valid) begin
        req_cnt++;
        chk({nm, " req_addr"}, mem_if.mem_req_addr, {a[31:2], 2'b00});
        chk({nm, " req_we"}, mem_if.mem_req_we, 0);
      end
      if (Fill_en) begin
        fill_cnt++;
        fill_cyc = c;
        chk({nm, " fill_way"},   Fill_way,   w);
        chk({nm, " fill_index"}, Fill_index, a[9:2]);
        chk({nm, " fill_tag"},   Fill_tag,   a[31:10]);
        chk({nm, " fill_data"},  Fill_data,  d);
      end
      @(posedge clk); #1;
      BLK  = w_later;
      Addr = a ^ 32'hFFFF_0000;
      mem_if.mem_resp_valid = (c + 1 == 1 + L) || (c + 1 == 1 && L >= 2);
      mem_if.mem_resp_data  = (c + 1 == 1 + L) ? d : (32'hBAD0_0000 | c);
      Hit = (c + 1 >= 3 + L);
    end
    Usecache = 1'b0; Hit = 1'b0; mem_if.mem_resp_valid = 1'b0;
    chk({nm, " stall_cycles"}, stall_cnt, 3 + L);
    chk({nm, " fill_count"},   fill_cnt,  1);
    chk({nm, " fill_cycle"},   fill_cyc,  2 + L);
    chk({nm, " req_cycles"},   req_cnt,   1);
  endtask

  typedef struct {
    logic use_c;
    logic we;
    logic hit;
    logic exp_stall;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    int stall_cnt, fill_cnt, req_cnt, first_low, req2_c;
    int          fc [$];
    logic [31:0] fd [$];
    logic [1:0]  fw [$];
    logic [7:0]  fi [$];

    // IDLE stall decode: Stall = Usecache & (MemWrite | ~Hit)
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    Usecache = 1'b0; MemWrite = 1'b0; Hit = 1'b0;
    Addr = 32'h0; WriteData = 32'h0; BLK = 2'd0;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data  = 32'h0;

    // Held in reset the FSM sits in IDLE, so the table exercises the
    // IDLE decode without starting transactions.
    repeat (2) @(posedge clk);
    chk("reset fill_way",   Fill_way,   0);
    chk("reset fill_index", Fill_index, 0);
    chk("reset fill_tag",   Fill_tag,   0);
    chk("reset fill_data",  Fill_data,  0);
    for (int i = 0; i < 8; i++) begin
      Usecache = vecs[i].use_c; MemWrite = vecs[i].we; Hit = vecs[i].hit;
      #2;
      chk($sformatf("idle_stall vec%0d", i), Stall, vecs[i].exp_stall);
      chk($sformatf("reset req_valid vec%0d", i), mem_if.mem_req_valid, 0);
      chk($sformatf("reset fill_en vec%0d", i), Fill_en, 0);
    end
    Usecache = 1'b0; MemWrite = 1'b0; Hit = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Read miss 0x1234, way 2, L=3: index 0x8D, tag 0x4, six stall cycles
    read_miss(32'h0000_1234, 2'd2, 2'd2, 32'hDEAD_BEEF, 3, "rd1");

    // Read hit: nothing happens
    stall_cnt = 0; fill_cnt = 0; req_cnt = 0;
    Usecache = 1'b1; MemWrite = 1'b0; Hit = 1'b1; Addr = 32'h0000_0040;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (Stall) stall_cnt++;
      if (Fill_en) fill_cnt++;
      if (mem_if.mem_req_valid) req_cnt++;
      @(posedge clk); #1;
    end
    Usecache = 1'b0; Hit = 1'b0;
    chk("hit stall_cycles", stall_cnt, 0);
    chk("hit fill_count",   fill_cnt,  0);
    chk("hit req_cycles",   req_cnt,   0);

    // Store 0x55AA55AA to 0x400 with ready low 4 cycles, spurious response
    // during WR_REQ, ack at cycle 6 -> DONE (Stall=0) at cycle 7.
    stall_cnt = 0; fill_cnt = 0; req_cnt = 0; first_low = -1;
    Usecache = 1'b1; MemWrite = 1'b1; Hit = 1'b0; BLK = 2'd0;
    Addr = 32'h0000_0400; WriteData = 32'h55AA_55AA;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (Stall) stall_cnt++;
      else if (first_low < 0) first_low = c;
      if (Fill_en) fill_cnt++;
      if (mem_if.mem_req_valid) begin
        req_cnt++;
        chk("st req_addr",  mem_if.mem_req_addr,  32'h0000_0400);
        chk("st req_we",    mem_if.mem_req_we,    1);
        chk("st req_wdata", mem_if.mem_req_wdata, 32'h55AA_55AA);
      end
      @(posedge clk); #1;
      Addr      = 32'h1230_0000 + (c + 1);
      WriteData = 32'hA5A5_0000 + (c + 1);
      mem_if.mem_req_ready  = (c + 1 == 5);
      mem_if.mem_resp_valid = (c + 1 == 6) || (c + 1 == 3);
      mem_if.mem_resp_data  = 32'h7777_0000 + (c + 1);
      Usecache = (c + 1 < 8);
    end
    Usecache = 1'b0; MemWrite = 1'b0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
    chk("st stall_cycles", stall_cnt, 7);
    chk("st done_cycle",   first_low, 7);
    chk("st req_cycles",   req_cnt,   5);
    chk("st fill_count",   fill_cnt,  0);

    // BLK_NUM moves 1 -> 3 after detection; fill must use way 1. Also L=1
    // gives the minimum four-cycle penalty.
    read_miss(32'h0000_2008, 2'd1, 2'd3, 32'h0123_4567, 2, "blk");
    read_miss(32'h0000_0C0C, 2'd3, 2'd0, 32'h89AB_CDEF, 1, "min");

    // Reset during RD_WAIT aborts; a late response must not fill.
    Usecache = 1'b1; MemWrite = 1'b0; Hit = 1'b0; Addr = 32'h0000_3004; BLK = 2'd2;
    mem_if.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst detect stall", Stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst rd_req valid", mem_if.mem_req_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst rd_wait valid", mem_if.mem_req_valid, 0);
    chk("rst rd_wait stall", Stall, 1);
    #2;
    rst_n = 1'b0; Usecache = 1'b0;
    #1;
    chk("rst abort stall",     Stall,                0);
    chk("rst abort req_valid", mem_if.mem_req_valid, 0);
    chk("rst abort fill_tag",  Fill_tag,             0);
    chk("rst abort fill_idx",  Fill_index,           0);
    chk("rst abort fill_data", Fill_data,            0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_data = 32'hCAFE_F00D;
    fill_cnt = 0; stall_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (Fill_en) fill_cnt++;
      if (Stall) stall_cnt++;
      @(posedge clk); #1;
      mem_if.mem_resp_valid = (c + 1 < 2);
    end
    chk("rst late fill_count",   fill_cnt,  0);
    chk("rst late stall_cycles", stall_cnt, 0);

    // Back-to-back misses: A (0x10, way 0, L=1) fills at cycle 3, B (0x20,
    // way 3) is presented in IDLE at cycle 4, requests at 5, fills at 7.
    stall_cnt = 0; req2_c = -1;
    Usecache = 1'b1; MemWrite = 1'b0; Hit = 1'b0; Addr = 32'h0000_0010; BLK = 2'd0;
    mem_if.mem_req_ready = 1'b1; mem_if.mem_resp_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (Stall) stall_cnt++;
      if (mem_if.mem_req_valid && c > 2 && req2_c < 0) req2_c = c;
      if (Fill_en) begin
        fc.push_back(c); fd.push_back(Fill_data);
        fw.push_back(Fill_way); fi.push_back(Fill_index);
      end
      @(posedge clk); #1;
      mem_if.mem_resp_valid = (c + 1 == 2) || (c + 1 == 6);
      mem_if.mem_resp_data  = (c + 1 == 2) ? 32'h1111_AAAA : 32'h2222_BBBB;
      if (c + 1 == 4) begin
        Addr = 32'h0000_0020; BLK = 2'd3;
      end
      Hit      = (c + 1 >= 8);
      Usecache = (c + 1 < 9);
    end
    Usecache = 1'b0; Hit = 1'b0; mem_if.mem_resp_valid = 1'b0;
    chk("b2b fill_count",   fc.size(), 2);
    chk("b2b stall_cycles", stall_cnt, 8);
    chk("b2b req2_cycle",   req2_c,    5);
    if (fc.size() >= 2) begin
      chk("b2b fill0 cycle", fc[0], 3);
      chk("b2b fill0 data",  fd[0], 32'h1111_AAAA);
      chk("b2b fill0 way",   fw[0], 0);
      chk("b2b fill0 index", fi[0], 8'h04);
      chk("b2b fill1 cycle", fc[1], 7);
      chk("b2b fill1 data",  fd[1], 32'h2222_BBBB);
      chk("b2b fill1 way",   fw[1], 3);
      chk("b2b fill1 index", fi[1], 8'h08);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cache_miss_handler
`default_nettype wire
